// File: rtl/seq_pattern_tx_if.sv
// ---------------------------------------------------------------------------
// seq_pattern_tx_if
//
// Groups the control and serial-output signals of the serial pattern
// transmitter so a driver (bench or link-test controller) and the transmitter
// can be connected with a single port.
//
// Signals:
//   start       - request a transmission (accepted only while ready=1)
//   abort       - terminate an active transmission
//   pat_in      - pattern; bit pat_len-1 is sent first
//   pat_len     - pattern length, legal range 1..MAX_LEN
//   rep_cnt     - repetitions, 0 = continuous until abort
//   gap_cyc     - idle cycles between repetitions
//   ready       - transmitter idle and able to accept start
//   x           - serial data (0 whenever x_valid=0)
//   x_valid     - x carries a pattern bit this cycle
//   busy        - transmission in progress (sending or gapping)
//   frame_start - pulse with the first bit of each repetition
//   done        - pulse at the end of a transmission, normal or aborted
//   err         - pulse on a rejected start
//
// Modports:
//   master - the side that requests transmissions
//   slave  - the transmitter itself
// ---------------------------------------------------------------------------
interface seq_pattern_tx_if #(
    parameter int MAX_LEN = 16,
    parameter int LW      = 5,
    parameter int CW      = 8
);

    logic               start;
    logic               abort;
    logic [MAX_LEN-1:0] pat_in;
    logic [LW-1:0]      pat_len;
    logic [CW-1:0]      rep_cnt;
    logic [CW-1:0]      gap_cyc;

    logic               ready;
    logic               x;
    logic               x_valid;
    logic               busy;
    logic               frame_start;
    logic               done;
    logic               err;

    modport master (
        output start, abort, pat_in, pat_len, rep_cnt, gap_cyc,
        input  ready, x, x_valid, busy, frame_start, done, err
    );

    modport slave (
        input  start, abort, pat_in, pat_len, rep_cnt, gap_cyc,
        output ready, x, x_valid, busy, frame_start, done, err
    );

endinterface

// File: rtl/seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// seq_pattern_tx
//
// Serial pattern transmitter: the source end of the single-bit stimulus line
// feeding the sequence detectors. On an accepted start it latches a pattern,
// its length, a repetition count and an inter-repetition gap, then shifts the
// pattern out MSB-first (bit pat_len-1 first), one bit per clock. Supports
// back-to-back repetition, idle gaps between repetitions, continuous mode
// (rep_cnt=0) and abort.
//
// Parameters:
//   MAX_LEN - maximum pattern length in bits
//   LW      - width of pat_len (2**LW > MAX_LEN)
//   CW      - width of rep_cnt / gap_cyc
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - seq_pattern_tx_if slave modport (controls in, serial line out)
//
// All outputs are registered. The first bit appears one cycle after the edge
// that accepts start.
// ---------------------------------------------------------------------------
module seq_pattern_tx #(
    parameter int MAX_LEN = 16,
    parameter int LW      = 5,
    parameter int CW      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_pattern_tx_if.slave   bus
);

    localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } state_t;

    // Control state and latched transaction parameters
    state_t             state_q,  state_d;
    logic [MAX_LEN-1:0] pat_q,    pat_d;
    logic [LW-1:0]      len_q,    len_d;
    logic [LW-1:0]      idx_q,    idx_d;
    logic [CW-1:0]      rep_q,    rep_d;
    logic               cont_q,   cont_d;
    logic [CW-1:0]      gap_q,    gap_d;
    logic [CW-1:0]      gcnt_q,   gcnt_d;

    // Registered outputs
    logic ready_q, ready_d;
    logic x_q,     x_d;
    logic xv_q,    xv_d;
    logic busy_q,  busy_d;
    logic fs_q,    fs_d;
    logic done_q,  done_d;
    logic err_q,   err_d;

    // Helpers for the next-state logic
    logic               len_legal;
    logic               more_reps;
    logic [MAX_LEN-1:0] bit_src;
    logic [MAX_LEN-1:0] bit_sh;

    // State and output register bank. Reset returns everything to a quiet
    // idle line with ready asserted, discarding any partial stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            cont_q  <= 1'b0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            ready_q <= 1'b1;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
            busy_q  <= 1'b0;
            fs_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            cont_q  <= cont_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            ready_q <= ready_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            busy_q  <= busy_d;
            fs_q    <= fs_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state and next-output logic. The outputs computed here describe
    // the cycle after the coming edge, which is what keeps every output
    // registered. Abort has priority over a pattern-end transition; both
    // land in DONE anyway.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        cont_d    = cont_q;
        gap_d     = gap_q;
        gcnt_d    = gcnt_q;
        ready_d   = 1'b0;
        xv_d      = 1'b0;
        busy_d    = 1'b0;
        fs_d      = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        x_d       = 1'b0;
        more_reps = cont_q || (rep_q > CW'(1));
        len_legal = (bus.pat_len != '0) && (bus.pat_len <= MAX_LEN_L);
        bit_src   = pat_q;
        bit_sh    = '0;

        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.start) begin
                    if (len_legal) begin
                        pat_d   = bus.pat_in;
                        len_d   = bus.pat_len;
                        rep_d   = bus.rep_cnt;
                        cont_d  = (bus.rep_cnt == '0);
                        gap_d   = bus.gap_cyc;
                        idx_d   = bus.pat_len - 1'b1;
                        bit_src = bus.pat_in;
                        state_d = SEND;
                        ready_d = 1'b0;
                        xv_d    = 1'b1;
                        busy_d  = 1'b1;
                        fs_d    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            SEND: begin
                if (bus.abort) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (idx_q != '0) begin
                    idx_d  = idx_q - 1'b1;
                    xv_d   = 1'b1;
                    busy_d = 1'b1;
                end else begin
                    // Bit 0 is on the line: one repetition is complete.
                    // Continuous mode never consumes the repetition count.
                    if (!cont_q) begin
                        rep_d = rep_q - 1'b1;
                    end
                    if (!more_reps) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (gap_q != '0) begin
                        state_d = GAP;
                        gcnt_d  = gap_q;
                        busy_d  = 1'b1;
                    end else begin
                        idx_d  = len_q - 1'b1;
                        xv_d   = 1'b1;
                        busy_d = 1'b1;
                        fs_d   = 1'b1;
                    end
                end
            end

            GAP: begin
                // gcnt_q counts the gap cycles still to show, including the
                // current one, so the gap lasts exactly gap_cyc cycles.
                if (bus.abort) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (gcnt_q == CW'(1)) begin
                    state_d = SEND;
                    idx_d   = len_q - 1'b1;
                    xv_d    = 1'b1;
                    busy_d  = 1'b1;
                    fs_d    = 1'b1;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                    busy_d = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end

            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase

        // Serial data is the selected pattern bit, forced low off-pattern.
        bit_sh = bit_src >> idx_d;
        x_d    = xv_d & bit_sh[0];
    end

    assign bus.ready       = ready_q;
    assign bus.x           = x_q;
    assign bus.x_valid     = xv_q;
    assign bus.busy        = busy_q;
    assign bus.frame_start = fs_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_tx
//
// Self-checking bench for seq_pattern_tx. A behavioural model expands each
// transaction (pattern, length, repetitions, gap, abort point) into the
// expected per-cycle output sequence; every cycle of every transaction is
// compared against it. A table of directed transactions additionally checks
// hand-derived summary figures (bit stream, busy length, frame count, 1010
// detector hits). Random transactions and a mid-transmission reset follow.
// ---------------------------------------------------------------------------
module tb_seq_pattern_tx;

    localparam int MAX_LEN = 16;
    localparam int LW      = 5;
    localparam int CW      = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seq_pattern_tx_if #(.MAX_LEN(MAX_LEN), .LW(LW), .CW(CW)) bus ();

    seq_pattern_tx #(.MAX_LEN(MAX_LEN), .LW(LW), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic ready;
        logic xv;
        logic x;
        logic fs;
        logic busy;
        logic done;
        logic err;
    } cyc_t;

    typedef struct {
        string       name;
        logic [15:0] pat;
        int          len;
        int          reps;
        int          gap;
        int          abort_at;
        bit          noise;
        int          exp_err;
        int          exp_bits;
        int          exp_busy;
        int          exp_frames;
        logic [63:0] exp_stream;
        int          exp_det;
    } vec_t;

    cyc_t expq[$];
    vec_t vecs[$];

    function automatic cyc_t mk(logic ready, logic xv, logic x, logic fs,
                                logic busy, logic done, logic err);
        cyc_t c;
        c.ready = ready;
        c.xv    = xv;
        c.x     = x;
        c.fs    = fs;
        c.busy  = busy;
        c.done  = done;
        c.err   = err;
        return c;
    endfunction

    function automatic cyc_t sampleBus();
        return mk(bus.ready, bus.x_valid, bus.x, bus.frame_start,
                  bus.busy, bus.done, bus.err);
    endfunction

    // Expected line activity from the cycle after start onward: repetitions
    // of the pattern (MSB first) separated by gap cycles, cut short at the
    // abort point, followed by one done cycle and one ready cycle.
    function automatic void modelBuild(logic [15:0] pat, int len, int reps,
                                       int gap, int abort_at);
        int r = 0;
        expq.delete();
        if (len < 1 || len > MAX_LEN) begin
            expq.push_back(mk(1, 0, 0, 0, 0, 0, 1));
            expq.push_back(mk(1, 0, 0, 0, 0, 0, 0));
            return;
        end
        while ((reps == 0 || r < reps) && (abort_at == 0 || expq.size() < abort_at)
               && r < 400) begin
            if (r > 0) begin
                for (int g = 0; g < gap; g++) expq.push_back(mk(0, 0, 0, 0, 1, 0, 0));
            end
            for (int b = len - 1; b >= 0; b--) begin
                expq.push_back(mk(0, 1, pat[b], logic'(b == len - 1), 1, 0, 0));
            end
            r++;
        end
        while (abort_at != 0 && expq.size() > abort_at) void'(expq.pop_back());
        expq.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        expq.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    endfunction

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(logic [15:0] pat, int len, int reps, int gap, logic start);
        bus.pat_in  = pat;
        bus.pat_len = len[LW-1:0];
        bus.rep_cnt = reps[CW-1:0];
        bus.gap_cyc = gap[CW-1:0];
        bus.start   = start;
    endtask

    // Issues one start and checks every following cycle against the model.
    // With noise set, start is re-asserted with random fields while the
    // transmitter is not ready, which must have no effect.
    task automatic runTxn(string tag, logic [15:0] pat, int len, int reps, int gap,
                          int abort_at, bit noise,
                          output int o_err, output int o_bits, output int o_busy,
                          output int o_frames, output logic [63:0] o_stream,
                          output int o_det);
        cyc_t       obs;
        logic [3:0] hist;
        hist     = '0;
        o_err    = 0;
        o_bits   = 0;
        o_busy   = 0;
        o_frames = 0;
        o_stream = '0;
        o_det    = 0;
        modelBuild(pat, len, reps, gap, abort_at);
        bus.abort = 1'b0;
        applyStimulus(pat, len, reps, gap, 1'b1);
        for (int k = 0; k < expq.size(); k++) begin
            @(posedge clk);
            #1;
            obs = sampleBus();
            checkOutput($sformatf("%s_cyc%0d", tag, k), 64'(obs), 64'(expq[k]));
            if (obs.err) o_err++;
            if (obs.busy) o_busy++;
            if (obs.fs) o_frames++;
            if (obs.xv) begin
                o_bits++;
                o_stream = {o_stream[62:0], obs.x};
                hist = {hist[2:0], obs.x};
                if (hist == 4'b1010) o_det++;
            end
            bus.abort = logic'(abort_at != 0 && k + 1 == abort_at);
            if (noise && !expq[k].ready)
                applyStimulus(16'($urandom), $urandom_range(0, 17), $urandom_range(0, 255),
                              $urandom_range(0, 255), 1'b1);
            else
                bus.start = 1'b0;
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          o_err, o_bits, o_busy, o_frames, o_det;
        logic [63:0] o_stream;
        int          len, reps, gap, abort_at, total;

        vecs = '{
            '{"basic",   16'h000A, 4,   3, 0,  0, 1'b0, 0, 12, 12,   3, 64'hAAA,  5},
            '{"gap",     16'h000A, 4,   2, 3,  0, 1'b0, 0,  8, 11,   2, 64'hAA,   3},
            '{"len0",    16'h000A, 0,   1, 0,  0, 1'b0, 1,  0,  0,   0, 64'h0,    0},
            '{"len17",   16'h000A, 17,  1, 0,  0, 1'b0, 1,  0,  0,   0, 64'h0,    0},
            '{"cont",    16'h0009, 4,   0, 0, 10, 1'b0, 0, 10, 10,   3, 64'h266,  0},
            '{"full",    16'hF0A5, 16,  1, 0,  0, 1'b1, 0, 16, 16,   1, 64'hF0A5, 1},
            '{"rep255",  16'h0001, 1, 255, 0,  0, 1'b0, 0, 255, 255, 255, 64'hFFFF_FFFF_FFFF_FFFF, 0},
            '{"gapabrt", 16'h0003, 2,   0, 2,  7, 1'b0, 0,  4,  7,   2, 64'hF,    0},
            '{"endabrt", 16'h0005, 3,   2, 1,  7, 1'b0, 0,  6,  7,   2, 64'h2D,   0}
        };

        bus.abort = 1'b0;
        applyStimulus(16'h0, 1, 1, 0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 64'(sampleBus()), 64'(mk(1, 0, 0, 0, 0, 0, 0)));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_after_reset", 64'(sampleBus()), 64'(mk(1, 0, 0, 0, 0, 0, 0)));

        // Directed table
        for (int i = 0; i < vecs.size(); i++) begin
            runTxn(vecs[i].name, vecs[i].pat, vecs[i].len, vecs[i].reps, vecs[i].gap,
                   vecs[i].abort_at, vecs[i].noise,
                   o_err, o_bits, o_busy, o_frames, o_stream, o_det);
            checkOutput({vecs[i].name, "_err"},    64'(o_err),    64'(vecs[i].exp_err));
            checkOutput({vecs[i].name, "_bits"},   64'(o_bits),   64'(vecs[i].exp_bits));
            checkOutput({vecs[i].name, "_busy"},   64'(o_busy),   64'(vecs[i].exp_busy));
            checkOutput({vecs[i].name, "_frames"}, 64'(o_frames), 64'(vecs[i].exp_frames));
            checkOutput({vecs[i].name, "_stream"}, o_stream,      vecs[i].exp_stream);
            checkOutput({vecs[i].name, "_det"},    64'(o_det),    64'(vecs[i].exp_det));
        end

        // Reset in the middle of a transmission, after the second bit
        applyStimulus(16'h000A, 4, 1, 0, 1'b1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("pre_reset_bit2", 64'(sampleBus()), 64'(mk(0, 1, 0, 0, 1, 0, 0)));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 64'(sampleBus()), 64'(mk(1, 0, 0, 0, 0, 0, 0)));
        @(posedge clk);
        #1;
        checkOutput("held_reset", 64'(sampleBus()), 64'(mk(1, 0, 0, 0, 0, 0, 0)));
        rst_n = 1'b1;
        runTxn("post_reset", 16'h0006, 4, 1, 0, 0, 1'b0,
               o_err, o_bits, o_busy, o_frames, o_stream, o_det);
        checkOutput("post_reset_stream", o_stream, 64'h6);
        checkOutput("post_reset_frames", 64'(o_frames), 64'd1);

        // Randomized transactions against the model
        for (int t = 0; t < 30; t++) begin
            len = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 17)
                                              : $urandom_range(1, MAX_LEN);
            reps = $urandom_range(0, 4);
            gap = $urandom_range(0, 3);
            total = (reps == 0) ? 0 : len * reps + gap * (reps - 1);
            if (reps == 0)
                abort_at = $urandom_range(1, 40);
            else if ($urandom_range(0, 1) == 0 || total < 1)
                abort_at = 0;
            else
                abort_at = $urandom_range(1, total);
            runTxn($sformatf("rnd%0d", t), 16'($urandom), len, reps, gap, abort_at,
                   bit'($urandom_range(0, 1)),
                   o_err, o_bits, o_busy, o_frames, o_stream, o_det);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
